// File: rtl/tf_pkg.sv
// Shared defaults and FSM state type for the twiddle-factor generator.
package tf_pkg;
  localparam int          DATA_W_DEF  = 32;
  localparam int          D_W_DEF     = 4;
  localparam int          STAGES_DEF  = 4;
  localparam int          MUL_LAT_DEF = 2;
  localparam logic [31:0] Q_DEF       = 32'd97;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } tf_state_t;
endpackage

// File: rtl/tf_gen_seq_mod_mul_pipe.sv
// Fixed-latency modular multiplier: prod = (a*b) mod Q, MUL_LAT registered stages.
module mod_mul_pipe #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] Q       = 97,
  parameter int                MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              start,
  output logic [DATA_W-1:0] prod
);
  localparam logic [2*DATA_W-1:0] Q_EXT = {{DATA_W{1'b0}}, Q};

  logic [2*DATA_W-1:0] full_prod;
  logic [DATA_W-1:0]   red;
  logic [DATA_W-1:0]   stage_reg [MUL_LAT];

  assign full_prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign red       = DATA_W'(full_prod % Q_EXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) stage_reg[i] <= '0;
    end else begin
      if (start) stage_reg[0] <= red;
      for (int i = 1; i < MUL_LAT; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign prod = stage_reg[MUL_LAT-1];
endmodule

// File: rtl/tf_gen_seq.sv
// Twiddle-factor sequencer: per-stage base/step store, emits base*step^n mod Q
// one factor per accepted read, throttled while the multiplier is busy.
module tf_gen_seq
  import tf_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                D_W     = D_W_DEF,
  parameter int                STAGES  = STAGES_DEF,
  parameter int                MUL_LAT = MUL_LAT_DEF,
  parameter logic [DATA_W-1:0] Q       = DATA_W'(Q_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tf_init_base,
  input  logic              tf_init_const,
  input  logic              tf_ren,
  input  logic              tf_wen,
  input  logic [D_W-1:0]    it_depth_cnt,
  input  logic [DATA_W-1:0] base_in,
  input  logic [DATA_W-1:0] const_in,
  output logic [DATA_W-1:0] tf_out,
  output logic              tf_valid,
  output logic              tf_ready,
  output logic [D_W+7:0]    tf_idx,
  output logic              ren_drop
);
  localparam int SIDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int CNT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [D_W:0] STAGES_EXT = (D_W+1)'(STAGES);

  tf_state_t         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              do_init, do_wen, do_ren, do_drop, mul_done;
  logic              in_range;
  logic [SIDX_W-1:0] sidx;
  logic [STAGES-1:0] base_we, step_we;
  logic [DATA_W-1:0] base_reg [STAGES];
  logic [DATA_W-1:0] step_reg [STAGES];
  logic [DATA_W-1:0] cur_reg, step_sel, prod;
  logic [DATA_W-1:0] tf_out_reg;
  logic              tf_valid_reg, ren_drop_reg;
  logic [D_W+7:0]    tf_idx_reg;

  assign in_range = ({1'b0, it_depth_cnt} < STAGES_EXT);
  assign sidx     = it_depth_cnt[SIDX_W-1:0];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_we
      assign base_we[gi] = in_range && (sidx == SIDX_W'(gi)) && (do_init || do_wen);
      assign step_we[gi] = in_range && (sidx == SIDX_W'(gi)) && tf_init_const;
    end
  endgenerate

  // Out-of-range stages multiply by 1 so cur holds while still emitting.
  assign step_sel = in_range ? step_reg[sidx] : DATA_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    do_init    = 1'b0;
    do_wen     = 1'b0;
    do_ren     = 1'b0;
    do_drop    = 1'b0;
    mul_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tf_init_base) begin
          do_init = 1'b1;
        end else if (tf_wen) begin
          do_wen = 1'b1;
        end else if (tf_ren) begin
          do_ren     = 1'b1;
          state_next = MUL_WAIT;
          cnt_next   = CNT_W'(MUL_LAT - 1);
        end
      end
      MUL_WAIT: begin
        do_drop = tf_ren;
        if (cnt_reg == '0) begin
          mul_done   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  mod_mul_pipe #(
    .DATA_W (DATA_W),
    .Q      (Q),
    .MUL_LAT(MUL_LAT)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .a    (cur_reg),
    .b    (step_sel),
    .start(do_ren),
    .prod (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        base_reg[i] <= '0;
        step_reg[i] <= '0;
      end
      cur_reg      <= '0;
      tf_out_reg   <= '0;
      tf_valid_reg <= 1'b0;
      tf_idx_reg   <= '0;
      ren_drop_reg <= 1'b0;
    end else begin
      tf_valid_reg <= do_ren;
      if (do_ren) begin
        tf_out_reg <= cur_reg;
        tf_idx_reg <= tf_idx_reg + 1'b1;
      end
      if (do_init && in_range) begin
        cur_reg    <= base_in;
        tf_idx_reg <= '0;
      end
      if (mul_done) cur_reg <= prod;
      if (do_drop) ren_drop_reg <= 1'b1;
      for (int i = 0; i < STAGES; i++) begin
        if (base_we[i]) base_reg[i] <= do_init ? base_in : cur_reg;
        if (step_we[i]) step_reg[i] <= const_in;
      end
    end
  end

  assign tf_out   = tf_out_reg;
  assign tf_valid = tf_valid_reg;
  assign tf_ready = (state_reg == IDLE);
  assign tf_idx   = tf_idx_reg;
  assign ren_drop = ren_drop_reg;
endmodule
